// File: rtl/rvvi_frame_decoder.sv
// rvvi_frame_decoder: receive end of the compressed rvvi trace link.
// Ports: clk/reset_n; Rx* beat stream in (valid/ready/last);
//   Ret* retire record out (valid/ready); Csr* CSR records out
//   (valid/ready/last); LenErr/SeqErr sticky error flags.
// Optional macro RVVI_DECODE_SEQCHK_EN enables frame-count
//   continuity checking; when undefined SeqErr is tied 0.
module rvvi_frame_decoder #(
  parameter int XLEN              = 64,
  parameter int MAX_CSRS          = 5,
  parameter int FRAME_COUNT_WIDTH = 16,
  parameter int BEAT_WIDTH        = 32,
  parameter int RVVI_WIDTH        = 64+4*XLEN+MAX_CSRS*(XLEN+16),
  parameter int NBEATS            =
    (RVVI_WIDTH+BEAT_WIDTH-1)/BEAT_WIDTH
)(
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [BEAT_WIDTH-1:0]        RxData,
  input  logic                         RxValid,
  input  logic                         RxLast,
  output logic                         RxReady,
  output logic                         RetValid,
  input  logic                         RetReady,
  output logic [XLEN-1:0]              RetPC,
  output logic [31:0]                  RetInstr,
  output logic [63:0]                  RetMcycle,
  output logic [63:0]                  RetMinstret,
  output logic                         RetTrap,
  output logic [1:0]                   RetPriv,
  output logic                         RetGPRWen,
  output logic                         RetFPRWen,
  output logic [4:0]                   RetRegAddr,
  output logic [XLEN-1:0]              RetRegValue,
  output logic [11:0]                  RetCSRCount,
  output logic [FRAME_COUNT_WIDTH-1:0] RetFrameCount,
  output logic                         CsrValid,
  input  logic                         CsrReady,
  output logic [11:0]                  CsrAddr,
  output logic [XLEN-1:0]              CsrValue,
  output logic                         CsrLast,
  output logic                         LenErr,
  output logic                         SeqErr
);

  localparam int FW  = NBEATS*BEAT_WIDTH;
  localparam int BCW = $clog2(NBEATS+1);
  localparam int JW  = (MAX_CSRS > 1) ? $clog2(MAX_CSRS) : 1;
  localparam int R   = 56+3*XLEN;
  localparam int S0  = R+XLEN+8;
  localparam int SW  = XLEN+16;

  localparam logic [BCW-1:0] LASTB  = BCW'(NBEATS-1);
  localparam logic [BCW-1:0] BC_ONE = BCW'(1);
  localparam logic [JW-1:0]  J_ONE  = JW'(1);
  localparam logic [11:0]    MAXC   = 12'(MAX_CSRS);

  typedef enum logic [1:0] {
    HDR, COLLECT, RET, CSR
  } state_t;

  state_t                       r_state;
  logic [FW-1:0]                r_frame;
  logic [BCW-1:0]               r_bcnt;
  logic                         r_drop;
  logic [JW-1:0]                r_j;
  logic [FRAME_COUNT_WIDTH-1:0] r_fcnt;
  logic                         r_rx_ready;
  logic                         r_ret_valid;
  logic                         r_csr_valid;
  logic                         r_csr_last;
  logic                         r_len_err;

  logic                         w_rx_hs;
  logic                         w_ret_hs;
  logic                         w_csr_hs;
  logic [11:0]                  w_cnt;
  logic [11:0]                  w_n;
  logic                         w_last_j;
  logic [FRAME_COUNT_WIDTH-1:0] w_hdr;
  logic                         w_seq_err;
  logic                         w_unused;

  assign w_rx_hs  = RxValid & r_rx_ready;
  assign w_ret_hs = r_ret_valid & RetReady;
  assign w_csr_hs = r_csr_valid & CsrReady;
  assign w_hdr    = RxData[FRAME_COUNT_WIDTH-1:0];
  assign w_cnt    = r_frame[XLEN+168 +: 12];
  assign w_n      = (w_cnt > MAXC) ? MAXC : w_cnt;
  assign w_last_j = (12'(r_j) == (w_n - 12'd1));
  assign w_unused = ^r_frame;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= HDR;
      r_frame     <= '0;
      r_bcnt      <= '0;
      r_drop      <= 1'b0;
      r_j         <= '0;
      r_fcnt      <= '0;
      r_rx_ready  <= 1'b0;
      r_ret_valid <= 1'b0;
      r_csr_valid <= 1'b0;
      r_csr_last  <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      unique case (r_state)
        HDR: begin
          r_rx_ready <= 1'b1;
          if (w_rx_hs) begin
            if (RxLast) begin
              r_len_err <= 1'b1;
            end else begin
              r_fcnt  <= w_hdr;
              r_bcnt  <= '0;
              r_drop  <= 1'b0;
              r_state <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (w_rx_hs) begin
            if (!r_drop) begin
              r_frame[int'(r_bcnt)*BEAT_WIDTH +: BEAT_WIDTH]
                <= RxData;
              r_bcnt <= r_bcnt + BC_ONE;
            end
            if (RxLast) begin
              if (!r_drop && r_bcnt == LASTB) begin
                r_state     <= RET;
                r_rx_ready  <= 1'b0;
                r_ret_valid <= 1'b1;
              end else begin
                r_len_err <= 1'b1;
                r_state   <= HDR;
              end
            end else if (!r_drop && r_bcnt == LASTB) begin
              // overlong frame: swallow beats until RxLast
              r_len_err <= 1'b1;
              r_drop    <= 1'b1;
            end
          end
        end
        RET: begin
          if (w_cnt > MAXC) r_len_err <= 1'b1;
          if (w_ret_hs) begin
            r_ret_valid <= 1'b0;
            r_j         <= '0;
            if (w_n != 12'd0) begin
              r_state     <= CSR;
              r_csr_valid <= 1'b1;
              r_csr_last  <= (w_n == 12'd1);
            end else begin
              r_state    <= HDR;
              r_rx_ready <= 1'b1;
            end
          end
        end
        CSR: begin
          if (w_csr_hs) begin
            if (w_last_j) begin
              r_state     <= HDR;
              r_csr_valid <= 1'b0;
              r_csr_last  <= 1'b0;
              r_rx_ready  <= 1'b1;
            end else begin
              r_j        <= r_j + J_ONE;
              r_csr_last <= ((12'(r_j) + 12'd2) == w_n);
            end
          end
        end
        default: r_state <= HDR;
      endcase
    end
  end

`ifdef RVVI_DECODE_SEQCHK_EN
  localparam logic [FRAME_COUNT_WIDTH-1:0] FC_ONE =
    FRAME_COUNT_WIDTH'(1);

  logic [FRAME_COUNT_WIDTH-1:0] r_exp;
  logic                         r_have_exp;
  logic                         r_seq_err;

  // first header after reset only loads the expectation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_exp      <= '0;
      r_have_exp <= 1'b0;
      r_seq_err  <= 1'b0;
    end else if (w_rx_hs && r_state == HDR && !RxLast) begin
      if (r_have_exp && (w_hdr != (r_exp + FC_ONE)))
        r_seq_err <= 1'b1;
      r_exp      <= w_hdr;
      r_have_exp <= 1'b1;
    end
  end

  assign w_seq_err = r_seq_err;
`else
  assign w_seq_err = 1'b0;
`endif

  assign RxReady       = r_rx_ready;
  assign RetValid      = r_ret_valid;
  assign RetPC         = r_frame[XLEN-1:0];
  assign RetInstr      = r_frame[XLEN +: 32];
  assign RetMcycle     = r_frame[XLEN+32 +: 64];
  assign RetMinstret   = r_frame[XLEN+96 +: 64];
  assign RetTrap       = r_frame[XLEN+160];
  assign RetPriv       = r_frame[XLEN+161 +: 2];
  assign RetGPRWen     = r_frame[XLEN+163];
  assign RetFPRWen     = r_frame[XLEN+164];
  assign RetCSRCount   = w_cnt;
  assign RetRegAddr    = r_frame[R +: 5];
  assign RetRegValue   = r_frame[R+8 +: XLEN];
  assign RetFrameCount = r_fcnt;
  assign CsrValid      = r_csr_valid;
  assign CsrLast       = r_csr_last;
  assign CsrAddr       = r_frame[S0+int'(r_j)*SW +: 12];
  assign CsrValue      = r_frame[S0+int'(r_j)*SW+16 +: XLEN];
  assign LenErr        = r_len_err;
  assign SeqErr        = w_seq_err;

endmodule

// File: tb/tb_rvvi_frame_decoder.sv
// tb_rvvi_frame_decoder: directed bench for rvvi_frame_decoder.
// Frames are built from hand-placed field offsets (XLEN=64).
module tb_rvvi_frame_decoder;

  localparam int FW = 736;

`ifdef RVVI_DECODE_SEQCHK_EN
  localparam logic SEQ_EXP = 1'b1;
`else
  localparam logic SEQ_EXP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] RxData = '0;
  logic        RxValid = 1'b0;
  logic        RxLast = 1'b0;
  logic        RxReady;
  logic        RetValid;
  logic        RetReady = 1'b0;
  logic [63:0] RetPC;
  logic [31:0] RetInstr;
  logic [63:0] RetMcycle;
  logic [63:0] RetMinstret;
  logic        RetTrap;
  logic [1:0]  RetPriv;
  logic        RetGPRWen;
  logic        RetFPRWen;
  logic [4:0]  RetRegAddr;
  logic [63:0] RetRegValue;
  logic [11:0] RetCSRCount;
  logic [15:0] RetFrameCount;
  logic        CsrValid;
  logic        CsrReady = 1'b0;
  logic [11:0] CsrAddr;
  logic [63:0] CsrValue;
  logic        CsrLast;
  logic        LenErr;
  logic        SeqErr;

  int n_tests = 0;
  int n_fail  = 0;

  logic [11:0] s_addr [5];
  logic [63:0] s_val  [5];

  always #5 clk = ~clk;

  rvvi_frame_decoder dut (
    .clk(clk), .reset_n(reset_n),
    .RxData(RxData), .RxValid(RxValid), .RxLast(RxLast),
    .RxReady(RxReady),
    .RetValid(RetValid), .RetReady(RetReady),
    .RetPC(RetPC), .RetInstr(RetInstr),
    .RetMcycle(RetMcycle), .RetMinstret(RetMinstret),
    .RetTrap(RetTrap), .RetPriv(RetPriv),
    .RetGPRWen(RetGPRWen), .RetFPRWen(RetFPRWen),
    .RetRegAddr(RetRegAddr), .RetRegValue(RetRegValue),
    .RetCSRCount(RetCSRCount), .RetFrameCount(RetFrameCount),
    .CsrValid(CsrValid), .CsrReady(CsrReady),
    .CsrAddr(CsrAddr), .CsrValue(CsrValue), .CsrLast(CsrLast),
    .LenErr(LenErr), .SeqErr(SeqErr)
  );

  function automatic logic [FW-1:0] mk(
    input logic [63:0] pc, input logic [31:0] ins,
    input logic [4:0] ra, input logic [63:0] rv,
    input logic [11:0] cnt);
    logic [FW-1:0] f;
    f = '0;
    f[63:0]    = pc;
    f[95:64]   = ins;
    f[159:96]  = 64'h0000_0001_0000_0010;
    f[223:160] = 64'h0000_0000_0000_0020;
    f[226:225] = 2'b11;
    f[227]     = 1'b1;
    f[243:232] = cnt;
    f[252:248] = ra;
    f[319:256] = rv;
    for (int i = 0; i < 5; i++) begin
      f[320+80*i +: 12] = s_addr[i];
      f[336+80*i +: 64] = s_val[i];
    end
    return f;
  endfunction

  task automatic clr_slots();
    for (int i = 0; i < 5; i++) begin
      s_addr[i] = '0;
      s_val[i]  = '0;
    end
  endtask

  // called at a negedge, returns at the negedge after acceptance
  task automatic put_beat(input logic [31:0] d, input logic l);
    int t;
    RxData = d; RxValid = 1'b1; RxLast = l; t = 0;
    while (RxReady !== 1'b1 && t < 50) begin
      @(negedge clk); t++;
    end
    if (t == 50) begin
      n_tests++; n_fail++;
      $display("FAIL rx_timeout RxReady never asserted");
    end
    @(negedge clk);
    RxValid = 1'b0; RxLast = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] hdr,
                            input logic [FW-1:0] f,
                            input int last_at);
    put_beat({16'h0, hdr}, 1'b0);
    for (int k = 0; k <= last_at; k++)
      put_beat(f[k*32 +: 32], k == last_at);
  endtask

  task automatic take_ret();
    RetReady = 1'b1;
    @(negedge clk);
    RetReady = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    @(negedge clk);
    n_tests++; if (RxReady !== 1'b0) begin n_fail++; $display("FAIL rst_rxready got %b exp 0", RxReady); end
    n_tests++; if (RetValid !== 1'b0) begin n_fail++; $display("FAIL rst_retvalid got %b exp 0", RetValid); end
    n_tests++; if (CsrValid !== 1'b0) begin n_fail++; $display("FAIL rst_csrvalid got %b exp 0", CsrValid); end
    n_tests++; if ({LenErr, SeqErr} !== 2'b00) begin n_fail++; $display("FAIL rst_errs got %b exp 00", {LenErr, SeqErr}); end
    n_tests++; if (RetPC !== 64'h0) begin n_fail++; $display("FAIL rst_pc got %h exp 0", RetPC); end
    reset_n = 1'b1;
    @(negedge clk);
    n_tests++; if (RxReady !== 1'b1) begin n_fail++; $display("FAIL rst_release_rxready got %b exp 1", RxReady); end
  endtask

  task automatic test_basic();
    logic [FW-1:0] f;
    clr_slots();
    f = mk(64'h8000_0000, 32'h0050_0093, 5'd1, 64'd5, 12'd0);
    put_beat(32'h0000_0001, 1'b0);
    for (int k = 0; k < 22; k++) put_beat(f[k*32 +: 32], 1'b0);
    n_tests++; if (RetValid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b exp 0", RetValid); end
    put_beat(f[22*32 +: 32], 1'b1);
    n_tests++; if (RetValid !== 1'b1) begin n_fail++; $display("FAIL basic_latency got %b exp 1", RetValid); end
    n_tests++; if (RxReady !== 1'b0) begin n_fail++; $display("FAIL basic_rxready_ret got %b exp 0", RxReady); end
    n_tests++; if (RetPC !== 64'h8000_0000) begin n_fail++; $display("FAIL basic_pc got %h exp 80000000", RetPC); end
    n_tests++; if (RetInstr !== 32'h0050_0093) begin n_fail++; $display("FAIL basic_instr got %h exp 00500093", RetInstr); end
    n_tests++; if (RetMcycle !== 64'h1_0000_0010) begin n_fail++; $display("FAIL basic_mcycle got %h exp 100000010", RetMcycle); end
    n_tests++; if (RetMinstret !== 64'h20) begin n_fail++; $display("FAIL basic_minstret got %h exp 20", RetMinstret); end
    n_tests++; if ({RetTrap, RetPriv, RetGPRWen, RetFPRWen} !== 5'b0_11_1_0) begin n_fail++; $display("FAIL basic_flags got %b exp 01110", {RetTrap, RetPriv, RetGPRWen, RetFPRWen}); end
    n_tests++; if (RetRegAddr !== 5'd1) begin n_fail++; $display("FAIL basic_regaddr got %0d exp 1", RetRegAddr); end
    n_tests++; if (RetRegValue !== 64'd5) begin n_fail++; $display("FAIL basic_regval got %h exp 5", RetRegValue); end
    n_tests++; if (RetCSRCount !== 12'd0) begin n_fail++; $display("FAIL basic_csrcount got %0d exp 0", RetCSRCount); end
    n_tests++; if (RetFrameCount !== 16'h0001) begin n_fail++; $display("FAIL basic_fcnt got %h exp 0001", RetFrameCount); end
    take_ret();
    n_tests++; if (RetValid !== 1'b0) begin n_fail++; $display("FAIL basic_ret_drop got %b exp 0", RetValid); end
    n_tests++; if (CsrValid !== 1'b0) begin n_fail++; $display("FAIL basic_no_csr got %b exp 0", CsrValid); end
    n_tests++; if (RxReady !== 1'b1) begin n_fail++; $display("FAIL basic_rxready_back got %b exp 1", RxReady); end
    n_tests++; if (LenErr !== 1'b0) begin n_fail++; $display("FAIL basic_lenerr got %b exp 0", LenErr); end
  endtask

  task automatic test_csr();
    clr_slots();
    s_addr[0] = 12'h300; s_val[0] = 64'h8;
    s_addr[1] = 12'h341; s_val[1] = 64'h8000_0004;
    send_frame(16'h0002,
      mk(64'h8000_0004, 32'h3420_2373, 5'd6, 64'h7, 12'd2), 22);
    n_tests++; if (RetCSRCount !== 12'd2) begin n_fail++; $display("FAIL csr_count got %0d exp 2", RetCSRCount); end
    take_ret();
    for (int c = 0; c < 4; c++) begin
      n_tests++; if ({CsrValid, CsrLast, CsrAddr, CsrValue} !== {2'b10, 12'h300, 64'h8}) begin n_fail++; $display("FAIL csr_rec0_stall%0d got v%b l%b %h %h exp v1 l0 300 8", c, CsrValid, CsrLast, CsrAddr, CsrValue); end
      if (c < 3) @(negedge clk);
    end
    CsrReady = 1'b1;
    @(negedge clk);
    n_tests++; if ({CsrValid, CsrLast, CsrAddr, CsrValue} !== {2'b11, 12'h341, 64'h8000_0004}) begin n_fail++; $display("FAIL csr_rec1 got v%b l%b %h %h exp v1 l1 341 80000004", CsrValid, CsrLast, CsrAddr, CsrValue); end
    @(negedge clk);
    CsrReady = 1'b0;
    n_tests++; if (CsrValid !== 1'b0) begin n_fail++; $display("FAIL csr_done got %b exp 0", CsrValid); end
    n_tests++; if (RxReady !== 1'b1) begin n_fail++; $display("FAIL csr_rxready got %b exp 1", RxReady); end
  endtask

  task automatic test_len_short();
    clr_slots();
    send_frame(16'h0003,
      mk(64'hDEAD_0000, 32'h0, 5'd2, 64'h1, 12'd0), 10);
    n_tests++; if (LenErr !== 1'b1) begin n_fail++; $display("FAIL short_lenerr got %b exp 1", LenErr); end
    for (int c = 0; c < 3; c++) begin
      n_tests++; if (RetValid !== 1'b0) begin n_fail++; $display("FAIL short_no_ret%0d got %b exp 0", c, RetValid); end
      @(negedge clk);
    end
    send_frame(16'h0004,
      mk(64'h8000_0100, 32'h0010_0113, 5'd2, 64'h11, 12'd0), 22);
    n_tests++; if (RetValid !== 1'b1) begin n_fail++; $display("FAIL short_next_valid got %b exp 1", RetValid); end
    n_tests++; if (RetPC !== 64'h8000_0100) begin n_fail++; $display("FAIL short_next_pc got %h exp 80000100", RetPC); end
    n_tests++; if (RetRegValue !== 64'h11) begin n_fail++; $display("FAIL short_next_rv got %h exp 11", RetRegValue); end
    take_ret();
  endtask

  task automatic test_csr_overflow();
    int nrec;
    int lastk;
    do_reset();
    n_tests++; if (LenErr !== 1'b0) begin n_fail++; $display("FAIL ovf_lenerr_clr got %b exp 0", LenErr); end
    for (int i = 0; i < 5; i++) begin
      s_addr[i] = 12'h340 + 12'(i);
      s_val[i]  = 64'(i + 1);
    end
    send_frame(16'h0010,
      mk(64'h8000_0200, 32'h0000_0073, 5'd0, 64'h0, 12'd7), 22);
    n_tests++; if (RetCSRCount !== 12'd7) begin n_fail++; $display("FAIL ovf_count got %0d exp 7", RetCSRCount); end
    take_ret();
    CsrReady = 1'b1;
    nrec = 0; lastk = -1;
    for (int c = 0; c < 20; c++) begin
      if (CsrValid === 1'b1) begin
        n_tests++; if ({CsrAddr, CsrValue} !== {12'h340 + 12'(nrec), 64'(nrec + 1)}) begin n_fail++; $display("FAIL ovf_rec%0d got %h %h exp %h %h", nrec, CsrAddr, CsrValue, 12'h340 + 12'(nrec), nrec + 1); end
        if (CsrLast === 1'b1) lastk = nrec;
        nrec++;
      end
      @(negedge clk);
    end
    CsrReady = 1'b0;
    n_tests++; if (nrec !== 5) begin n_fail++; $display("FAIL ovf_nrec got %0d exp 5", nrec); end
    n_tests++; if (lastk !== 4) begin n_fail++; $display("FAIL ovf_lastpos got %0d exp 4", lastk); end
    n_tests++; if (LenErr !== 1'b1) begin n_fail++; $display("FAIL ovf_lenerr got %b exp 1", LenErr); end
  endtask

  task automatic test_seq();
    logic [15:0] hs [3];
    hs[0] = 16'hFFFE; hs[1] = 16'hFFFF; hs[2] = 16'h0000;
    do_reset();
    clr_slots();
    for (int i = 0; i < 3; i++) begin
      send_frame(hs[i],
        mk(64'h9000_0000 + 64'(i), 32'h13, 5'd3, 64'h3, 12'd0), 22);
      take_ret();
      n_tests++; if (SeqErr !== 1'b0) begin n_fail++; $display("FAIL seq_wrap%0d got %b exp 0", i, SeqErr); end
    end
    send_frame(16'h0005,
      mk(64'h9000_0100, 32'h13, 5'd4, 64'h44, 12'd0), 22);
    n_tests++; if (SeqErr !== SEQ_EXP) begin n_fail++; $display("FAIL seq_gap got %b exp %b", SeqErr, SEQ_EXP); end
    n_tests++; if (RetValid !== 1'b1) begin n_fail++; $display("FAIL seq_decode got %b exp 1", RetValid); end
    n_tests++; if (RetFrameCount !== 16'h0005) begin n_fail++; $display("FAIL seq_fcnt got %h exp 0005", RetFrameCount); end
    n_tests++; if (RetPC !== 64'h9000_0100) begin n_fail++; $display("FAIL seq_pc got %h exp 90000100", RetPC); end
    take_ret();
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] f;
    clr_slots();
    f = mk(64'hA000_0000, 32'h0020_0193, 5'd3, 64'h99, 12'd0);
    put_beat(32'h0000_0020, 1'b0);
    for (int k = 0; k < 12; k++) put_beat(f[k*32 +: 32], 1'b0);
    RxData = f[12*32 +: 32]; RxValid = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    n_tests++; if ({RxReady, RetValid, CsrValid, CsrLast} !== 4'b0000) begin n_fail++; $display("FAIL mid_ctrl got %b exp 0000", {RxReady, RetValid, CsrValid, CsrLast}); end
    n_tests++; if ({RetPC, RetRegValue} !== 128'h0) begin n_fail++; $display("FAIL mid_data got %h %h exp 0 0", RetPC, RetRegValue); end
    n_tests++; if ({RetFrameCount, CsrAddr, CsrValue} !== 92'h0) begin n_fail++; $display("FAIL mid_fcnt_csr got %h %h %h exp 0", RetFrameCount, CsrAddr, CsrValue); end
    n_tests++; if ({LenErr, SeqErr} !== 2'b00) begin n_fail++; $display("FAIL mid_errs got %b exp 00", {LenErr, SeqErr}); end
    RxValid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_frame(16'h0021, f, 22);
    n_tests++; if (RetValid !== 1'b1) begin n_fail++; $display("FAIL mid_after_valid got %b exp 1", RetValid); end
    n_tests++; if (RetPC !== 64'hA000_0000) begin n_fail++; $display("FAIL mid_after_pc got %h exp a0000000", RetPC); end
    n_tests++; if (RetFrameCount !== 16'h0021) begin n_fail++; $display("FAIL mid_after_fcnt got %h exp 0021", RetFrameCount); end
    n_tests++; if (RetRegValue !== 64'h99) begin n_fail++; $display("FAIL mid_after_rv got %h exp 99", RetRegValue); end
    take_ret();
    n_tests++; if (RxReady !== 1'b1) begin n_fail++; $display("FAIL mid_after_rxready got %b exp 1", RxReady); end
  endtask

  initial begin
    clr_slots();
    test_reset();
    test_basic();
    test_csr();
    test_len_short();
    test_csr_overflow();
    test_seq();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rvvi_frame_decoder.md
Name: rvvi_frame_decoder

Overview:
- Receive end of the compressed rvvi trace link.
- Accepts a frame serialized into fixed-width beats (valid/ready/last stream) and reassembles it into a frame register.
- Unpacks the frame into one retire record, then emits the frame's CSR updates one per handshake.
- Checks frame-count continuity and frame length.
- Sits in the host-side/FPGA capture path and in the loopback comparison bench.

Parameters:
- XLEN, 64, architectural register width.
- MAX_CSRS, 5, CSR slots per frame.
- FRAME_COUNT_WIDTH, 16, width of the frame counter carried in the header beat.
- BEAT_WIDTH, 32, stream beat width; must be ≥ FRAME_COUNT_WIDTH.
- RVVI_WIDTH, 64+4*XLEN+MAX_CSRS*(XLEN+16), frame payload width (720 at defaults).
- NBEATS, ceil(RVVI_WIDTH/BEAT_WIDTH), payload beats per frame (23 at defaults).

Ports:
- clk in 1: clock.
- reset_n in 1: asynchronous active-low reset.
- RxData in BEAT_WIDTH: stream beat.
- RxValid in 1: beat valid.
- RxLast in 1: marks the final beat of a frame.
- RxReady out 1: decoder accepts the beat.
- RetValid out 1: retire record valid.
- RetReady in 1: consumer accepts the retire record.
- RetPC out XLEN: retired PC.
- RetInstr out 32: retired instruction.
- RetMcycle out 64: mcycle.
- RetMinstret out 64: minstret.
- RetTrap out 1: trap flag.
- RetPriv out 2: privilege mode.
- RetGPRWen out 1: GPR write enable.
- RetFPRWen out 1: FPR write enable.
- RetRegAddr out 5: destination register address.
- RetRegValue out XLEN: destination register value.
- RetCSRCount out 12: CSR count from the frame.
- RetFrameCount out FRAME_COUNT_WIDTH: frame count from the header.
- CsrValid out 1: CSR record valid.
- CsrReady in 1: consumer accepts the CSR record.
- CsrAddr out 12: CSR address.
- CsrValue out XLEN: CSR value.
- CsrLast out 1: final CSR record of the frame.
- LenErr out 1: sticky frame-length error.
- SeqErr out 1: sticky frame-count sequence error.

Behaviour:

Frame format (LSB-first)
- Header beat: [FRAME_COUNT_WIDTH-1:0] = frame count; upper bits ignored.
- Then NBEATS payload beats; payload beat k carries frame bits [k*BEAT_WIDTH +: BEAT_WIDTH]. Bits above RVVI_WIDTH in the final beat are ignored.
- Payload field map, with R = 56+3*XLEN:
  - PC [XLEN-1:0]
  - Instr [XLEN+31:XLEN]
  - Mcycle [XLEN+95:XLEN+32]
  - Minstret [XLEN+159:XLEN+96]
  - Trap [XLEN+160]
  - Priv [XLEN+162:XLEN+161]
  - GPRWen [XLEN+163]
  - FPRWen [XLEN+164]
  - CSRCount [XLEN+179:XLEN+168]
  - RegAddr [R+4:R]
  - RegValue [R+XLEN+7:R+8]
  - CSR slot i at base S_i = R+XLEN+8+i*(XLEN+16): addr [S_i+11:S_i], value [S_i+XLEN+15:S_i+16].

State machine
- States: HDR, COLLECT, RET, CSR.
- HDR: RxReady=1. On beat accept, latch the frame count, clear the beat counter, go to COLLECT. If RxLast is set on the header beat: set LenErr, drop the frame, stay in HDR.
- COLLECT: RxReady=1. Each accepted beat is written at beat index bcnt, then bcnt increments.
  - RxLast with bcnt==NBEATS-1: go to RET.
  - RxLast earlier: set LenErr, discard the frame, go to HDR.
  - Beat NBEATS-1 without RxLast: set LenErr; further beats are accepted and discarded until RxLast, then go to HDR.
- RET: RxReady=0, RetValid=1, all Ret* fields stable. On RetValid&RetReady:
  - go to CSR if the effective count n>0 (slot index 0);
  - otherwise go to HDR.
- CSR: CsrValid=1, driving slot j. CsrLast=1 when j==n-1. On handshake, j increments; after the last slot, go to HDR.
- Effective count n = min(CSRCount, MAX_CSRS). If CSRCount>MAX_CSRS, LenErr is set and only MAX_CSRS records are emitted.
- Zero-bubble: Ret and Csr outputs hold stable while valid and not ready. RxReady returns to 1 in the cycle after the final handshake.
- Latency: RetValid asserts the cycle after the last payload beat is accepted.

Reset (reset_n low, async, any state)
- State=HDR, bcnt=0.
- RxReady=0 while in reset, 1 after.
- RetValid=0, CsrValid=0, CsrLast=0.
- All Ret* and Csr* data outputs = 0.
- LenErr=0, SeqErr=0.
- A frame in flight is discarded; no partial record is emitted.

Optional Feature:
- RVVI_DECODE_SEQCHK_EN
- Defined:
  - The decoder tracks the expected frame count, loaded from the first header after reset.
  - Each subsequent header must equal expected+1 mod 2^FRAME_COUNT_WIDTH, so 0xFFFF→0x0000 is legal.
  - On a mismatch: set SeqErr (sticky), resynchronize expected to the received value, and still decode the frame.
- Undefined: no tracking; SeqErr tied 0.

Test Plan:
- Header 0x0001, then 23 beats encoding PC=0x80000000, Instr=0x00500093, GPRWen=1, RegAddr=1, RegValue=5, CSRCount=0 -> RetValid asserts the cycle after the last beat with those fields. No CsrValid. RxReady=1 after RetReady.
- Frame with CSRCount=2, slot0=(0x300, 0x8), slot1=(0x341, 0x80000004), RetReady=1 and CsrReady low 3 cycles -> two Csr records in order, held stable during the stall; CsrLast only on 0x341.
- RxLast on payload beat 10 -> LenErr=1, no RetValid; the next well-formed frame decodes normally.
- CSRCount=7 -> exactly 5 Csr records; LenErr=1.
- With RVVI_DECODE_SEQCHK_EN: headers 0xFFFE, 0xFFFF, 0x0000 -> SeqErr=0. A following header 0x0005 -> SeqErr=1 and the frame still decodes.
- Assert reset_n low mid-COLLECT (beat 12) -> all outputs 0 immediately. After release, a fresh full frame decodes correctly.
